oc8051_cxrom_prefetch: RTL and testbench

//  Fetch-side initiator for the 8051 code ROM port: drives cxrom_addr, captures the
//  32-bit little-endian word returned combinationally by the cxrom responder, and keeps
//  a circular byte queue. Presents the next 3 instruction bytes to the decoder, which

---
 rtl/oc8051_cxrom_prefetch_pkg.sv | 7 +
 rtl/oc8051_pf_bytebuf.sv | 49 ++++
 rtl/oc8051_cxrom_prefetch.sv | 68 ++++++
 tb/tb_oc8051_cxrom_prefetch.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/oc8051_cxrom_prefetch_pkg.sv
// oc8051_cxrom_prefetch_pkg: shared fetch constants for the code-ROM prefetcher.
package oc8051_cxrom_prefetch_pkg;
    localparam int FETCH_BYTES = 4;
    localparam int OP_MAX = 3;
    localparam int DEPTH_DEFAULT = 8;
    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
endpackage

// File: rtl/oc8051_pf_bytebuf.sv
// oc8051_pf_bytebuf: circular byte queue with a 4-byte write port and 3 read taps at head.
module oc8051_pf_bytebuf
    import oc8051_cxrom_prefetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [31:0]   wr_data,
    input  logic [1:0]    rd_cnt,
    output logic [7:0]    op0,
    output logic [7:0]    op1,
    output logic [7:0]    op2,
    output logic [1:0]    op_cnt,
    output logic [CW-1:0] count
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + AW'(rd_cnt);
            tail  <= wr_en ? tail + AW'(FETCH_BYTES) : tail;
            count <= count + (wr_en ? CW'(FETCH_BYTES) : CW'(0)) - CW'(rd_cnt);
        end
    end

    // Storage is not reset: stale bytes are masked by count on the read side.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_BYTES; i++)
            if (wr_en && !rst && !clr) mem[tail + AW'(i)] <= wr_data[8*i +: 8];
    end

    always_comb begin
        op_cnt = (count >= CW'(OP_MAX)) ? 2'(OP_MAX) : count[1:0];
        op0    = (count > CW'(0)) ? mem[head] : 8'h00;
        op1    = (count > CW'(1)) ? mem[head + AW'(1)] : 8'h00;
        op2    = (count > CW'(2)) ? mem[head + AW'(2)] : 8'h00;
    end
endmodule

// File: rtl/oc8051_cxrom_prefetch.sv
// oc8051_cxrom_prefetch: code-ROM fetch initiator feeding up to 3 instruction bytes
// per cycle to the decoder, with PC redirect and sticky over-consume error.
module oc8051_cxrom_prefetch
    import oc8051_cxrom_prefetch_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] cxrom_addr,
    input  logic [31:0] cxrom_data_in,
    input  logic        pc_load,
    input  logic [15:0] pc_new,
    input  logic [1:0]  consume,
    output logic [7:0]  op0,
    output logic [7:0]  op1,
    output logic [7:0]  op2,
    output logic [1:0]  op_cnt,
    output logic [15:0] pc_out,
    output logic        err
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [15:0]   fetch_addr;
    logic [CW-1:0] count;
    logic          fetch;
    logic          over;
    logic [1:0]    eff;

    // Fetch decision uses the pre-consume count so a full word always fits.
    always_comb begin
        fetch = !pc_load && (count <= CW'(DEPTH - FETCH_BYTES));
        over  = consume > op_cnt;
        eff   = pc_load ? 2'd0 : (over ? op_cnt : consume);
    end

    oc8051_pf_bytebuf #(.DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (pc_load),
        .wr_en   (fetch),
        .wr_data (cxrom_data_in),
        .rd_cnt  (eff),
        .op0     (op0),
        .op1     (op1),
        .op2     (op2),
        .op_cnt  (op_cnt),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_addr <= RESET_PC;
            pc_out     <= RESET_PC;
            err        <= 1'b0;
        end else if (pc_load) begin
            fetch_addr <= pc_new;
            pc_out     <= pc_new;
        end else begin
            fetch_addr <= fetch ? fetch_addr + 16'(FETCH_BYTES) : fetch_addr;
            pc_out     <= pc_out + 16'(eff);
            err        <= err | over;
        end
    end

    assign cxrom_addr = fetch_addr;
endmodule

// File: tb/tb_oc8051_cxrom_prefetch.sv
// tb_oc8051_cxrom_prefetch: directed bench with a combinational ROM model byte[a] = a[7:0]^5A.
module tb_oc8051_cxrom_prefetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cxrom_addr;
    logic [31:0] cxrom_data_in;
    logic        pc_load;
    logic [15:0] pc_new;
    logic [1:0]  consume;
    logic [7:0]  op0, op1, op2;
    logic [1:0]  op_cnt;
    logic [15:0] pc_out;
    logic        err;

    int tests = 0;
    int fails = 0;
    int mcnt;
    int c;
    logic [15:0] mpc, maddr;

    always #5 clk = ~clk;

    function automatic logic [7:0] rb(input logic [15:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    always_comb cxrom_data_in = {rb(cxrom_addr + 16'd3), rb(cxrom_addr + 16'd2),
                                 rb(cxrom_addr + 16'd1), rb(cxrom_addr)};

    oc8051_cxrom_prefetch dut (
        .clk(clk), .rst(rst), .cxrom_addr(cxrom_addr), .cxrom_data_in(cxrom_data_in),
        .pc_load(pc_load), .pc_new(pc_new), .consume(consume),
        .op0(op0), .op1(op1), .op2(op2), .op_cnt(op_cnt), .pc_out(pc_out), .err(err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pc_load = 1'b0; pc_new = 16'h0; consume = 2'd0;
        step(); step();
        chk("rst_pc", 32'(pc_out), 32'h0);
        chk("rst_addr", 32'(cxrom_addr), 32'h0);
        chk("rst_opcnt", 32'(op_cnt), 32'd0);
        chk("rst_op0", 32'(op0), 32'h0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        step();
        chk("f1_addr", 32'(cxrom_addr), 32'h4);
        chk("f1_opcnt", 32'(op_cnt), 32'd3);
        chk("f1_op0", 32'(op0), 32'h5A);
        chk("f1_op1", 32'(op1), 32'h5B);
        chk("f1_op2", 32'(op2), 32'h58);
        step();
        chk("f2_addr", 32'(cxrom_addr), 32'h8);
        step();
        chk("full_addr", 32'(cxrom_addr), 32'h8);
        // Stream from a full queue, retiring as much as the decoder is offered.
        mcnt = 8; mpc = 16'h0; maddr = 16'h8;
        for (int k = 0; k < 20; k++) begin
            c = (mcnt >= 3) ? 3 : mcnt;
            chk("st_pc", 32'(pc_out), 32'(mpc));
            chk("st_addr", 32'(cxrom_addr), 32'(maddr));
            chk("st_opcnt", 32'(op_cnt), 32'(c));
            chk("st_op0", 32'(op0), (mcnt > 0) ? 32'(rb(mpc)) : 32'h0);
            chk("st_op1", 32'(op1), (mcnt > 1) ? 32'(rb(mpc + 16'd1)) : 32'h0);
            chk("st_op2", 32'(op2), (mcnt > 2) ? 32'(rb(mpc + 16'd2)) : 32'h0);
            consume = 2'(c);
            step();
            if (mcnt <= 4) begin
                mcnt += 4;
                maddr += 16'd4;
            end
            mcnt -= c;
            mpc += 16'(c);
        end
        consume = 2'd0;
        chk("st_err", 32'(err), 32'd0);
        pc_load = 1'b1; pc_new = 16'h1235; consume = 2'd2;
        step();
        pc_load = 1'b0; consume = 2'd0;
        chk("ld_pc", 32'(pc_out), 32'h1235);
        chk("ld_opcnt", 32'(op_cnt), 32'd0);
        chk("ld_addr", 32'(cxrom_addr), 32'h1235);
        chk("ld_op0z", 32'(op0), 32'h0);
        chk("ld_err", 32'(err), 32'd0);
        step();
        chk("ld_op0", 32'(op0), 32'h6F);
        chk("ld_op1", 32'(op1), 32'h6C);
        chk("ld_op2", 32'(op2), 32'h6D);
        chk("ld_opcnt3", 32'(op_cnt), 32'd3);
        pc_load = 1'b1; pc_new = 16'hFFFC;
        step();
        pc_load = 1'b0;
        chk("wr_addr0", 32'(cxrom_addr), 32'hFFFC);
        step();
        chk("wr_addr1", 32'(cxrom_addr), 32'h0000);
        step();
        chk("wr_addr2", 32'(cxrom_addr), 32'h0004);
        consume = 2'd2;
        step();
        consume = 2'd0;
        chk("wr_pc", 32'(pc_out), 32'hFFFE);
        chk("wr_op0", 32'(op0), 32'hA4);
        chk("wr_op1", 32'(op1), 32'hA5);
        chk("wr_op2", 32'(op2), 32'h5A);
        pc_load = 1'b1; pc_new = 16'h0100;
        step();
        pc_load = 1'b0; consume = 2'd2;
        step();
        consume = 2'd0;
        chk("ov_err", 32'(err), 32'd1);
        chk("ov_pc", 32'(pc_out), 32'h0100);
        chk("ov_opcnt", 32'(op_cnt), 32'd3);
        chk("ov_op0", 32'(op0), 32'(rb(16'h0100)));
        step(); step();
        chk("ov_sticky", 32'(err), 32'd1);
        pc_load = 1'b1; pc_new = 16'h0040;
        step();
        pc_load = 1'b0;
        step(); step();
        consume = 2'd2;
        step();
        consume = 2'd0;
        chk("pre_pc", 32'(pc_out), 32'h0042);
        chk("pre_op0", 32'(op0), 32'(rb(16'h0042)));
        rst = 1'b1; consume = 2'd3; pc_load = 1'b1; pc_new = 16'h7777;
        step();
        rst = 1'b0; consume = 2'd0; pc_load = 1'b0;
        chk("mr_pc", 32'(pc_out), 32'h0);
        chk("mr_addr", 32'(cxrom_addr), 32'h0);
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_opcnt", 32'(op_cnt), 32'd0);
        chk("mr_op0", 32'(op0), 32'h0);
        step();
        chk("mr_opcnt3", 32'(op_cnt), 32'd3);
        chk("mr_op0b", 32'(op0), 32'h5A);
        chk("mr_addr4", 32'(cxrom_addr), 32'h4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
